// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and received-word signals of the UART receiver.
// The slave modport is the receiver; the master modport is whatever drives the line and consumes words.
interface uart_rx_if;
  logic       serial_in;
  logic       data_width;
  logic       parity_en;
  logic       parity_type;
  logic       stop_bits;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  // data_valid is a one-cycle strobe with no ready: the consumer must take
  // data_out/parity_err/frame_err in the cycle data_valid is high (they also
  // hold until the next strobe).
  modport slave (
    input  serial_in, data_width, parity_en, parity_type, stop_bits,
    output data_out, data_valid, parity_err, frame_err, busy, dbg_state
  );

  modport master (
    output serial_in, data_width, parity_en, parity_type, stop_bits,
    input  data_out, data_valid, parity_err, frame_err, busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop with parity and framing flags.
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each sample point (needs CLKS_PER_BIT >= 8).
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] FULL_T = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_T = CNT_W'(CLKS_PER_BIT / 2 - 1);

  state_t           state, state_next;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_par;
  logic             ferr_int;
  logic             idle_armed;
  logic             cfg_w, cfg_pen, cfg_ptype, cfg_sb;
  logic [7:0]       data_q;
  logic             valid_q, perr_q, ferr_q;

  logic             hit, decide, bit_val, start_go, last_data, complete;
  logic [7:0]       word;
  logic             par_exp;

  assign rx_s = sync_q[1];

  assign target    = (state == S_START) ? HALF_T : FULL_T;
  assign hit       = (state != S_IDLE) && (cnt == target);
  assign start_go  = (state == S_IDLE) && !rx_s && idle_armed;
  assign last_data = (bit_idx == (cfg_w ? 3'd7 : 3'd6));
  assign word      = {cfg_w & shreg[7], shreg[6:0]};
  assign par_exp   = (^word) ^ cfg_ptype;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision lands one cycle after the nominal sample point; cnt already
  // restarted at the nominal point, so bit spacing stays one period.
  logic s_m1, s_0, vote_pend;
  assign decide  = vote_pend;
  assign bit_val = (s_m1 & s_0) | (s_m1 & rx_s) | (s_0 & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_m1      <= 1'b1;
      s_0       <= 1'b1;
      vote_pend <= 1'b0;
    end else begin
      if ((state != S_IDLE) && (cnt == target - CNT_W'(1))) s_m1 <= rx_s;
      if (hit) s_0 <= rx_s;
      vote_pend <= hit;
    end
  end
`else
  assign decide  = hit;
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      S_IDLE:   if (start_go) state_next = S_START;
      S_START:  if (decide) state_next = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (decide && last_data) state_next = cfg_pen ? S_PARITY : S_STOP1;
      S_PARITY: if (decide) state_next = S_STOP1;
      S_STOP1: begin
        if (decide) begin
          if (cfg_sb) begin
            state_next = S_STOP2;
          end else begin
            state_next = S_IDLE;
            complete   = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (decide) begin
          state_next = S_IDLE;
          complete   = 1'b1;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sync_q     <= 2'b11;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_par     <= 1'b0;
      ferr_int   <= 1'b0;
      idle_armed <= 1'b1;
      cfg_w      <= 1'b1;
      cfg_pen    <= 1'b0;
      cfg_ptype  <= 1'b0;
      cfg_sb     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.serial_in};
      state   <= state_next;
      valid_q <= complete;

      if (start_go) begin
        cnt       <= '0;
        ferr_int  <= 1'b0;
        cfg_w     <= bus.data_width;
        cfg_pen   <= bus.parity_en;
        cfg_ptype <= bus.parity_type;
        cfg_sb    <= bus.stop_bits;
      end else if (state != S_IDLE) begin
        cnt <= hit ? '0 : cnt + CNT_W'(1);
      end

      if (decide) begin
        case (state)
          S_START:  bit_idx <= '0;
          S_DATA: begin
            shreg[bit_idx] <= bit_val;
            bit_idx        <= bit_idx + 3'd1;
          end
          S_PARITY: rx_par <= bit_val;
          S_STOP1, S_STOP2: if (!bit_val) ferr_int <= 1'b1;
          default: ;
        endcase
      end

      // A line stuck low after a frame must go high before a new start counts.
      if (rx_s) idle_armed <= 1'b1;
      else if (complete) idle_armed <= 1'b0;

      if (complete) begin
        data_q <= word;
        perr_q <= cfg_pen & (rx_par != par_exp);
        ferr_q <= ferr_int | ~bit_val;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.dbg_state  = state;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the downstream consumer of the transmit datapath's serial_out line.
- Recovers start, data, parity and stop bits from an asynchronous serial line using a mid-bit sampling counter.
- Presents the received byte with a one-cycle valid strobe plus parity and framing error flags.
- Frame configuration inputs match the transmitter's: data_width, parity_en, parity_type, stop_bits.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range 4..65535.
- CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  reset: synchronous, active-high.
- serial_in  in  1  asynchronous serial line; idles high.
- data_width  in  1  1 = 8 data bits, 0 = 7 data bits.
- parity_en  in  1  1 = parity bit present after data.
- parity_type  in  1  0 = even, 1 = odd. Expected parity is ^data, inverted when parity_type=1.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- data_out  out  8  last received word, LSB first on the line; bit7 = 0 in 7-bit mode.
- data_valid  out  1  one-cycle strobe when a frame completes.
- parity_err  out  1  parity mismatch on the last frame; 0 when parity_en=0.
- frame_err  out  1  any sampled stop bit was 0 on the last frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - On rst high at a clk edge: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Synchronizer flops are set to 1, state=IDLE, counters cleared.
  - Reset mid-frame abandons the frame with no data_valid.
- Input synchronizer:
  - serial_in passes through 2 flops to give rx_s, i.e. 2 cycles of latency.
  - All decisions use rx_s only.
- Configuration:
  - data_width, parity_en, parity_type and stop_bits are latched on leaving IDLE.
  - Changes during a frame have no effect until the next frame.
- IDLE:
  - Waits for rx_s=0.
  - Then loads cnt=0 and enters START.
- START:
  - When cnt reaches (CLKS_PER_BIT/2)-1 (integer division), samples rx_s.
  - If the sample is 1: false start, return to IDLE, no flags change.
  - If the sample is 0: cnt=0, bit_idx=0, enter DATA.
- Bit sampling:
  - Every later sample is taken when cnt reaches CLKS_PER_BIT-1, i.e. one full bit period after the previous sample.
  - cnt clears at each sample.
- DATA:
  - Shifts the sample into shreg at bit_idx; bit_idx increments.
  - After the 8th sample (or the 7th when data_width=0), goes to PARITY if parity_en=1, else to STOP1.
- PARITY: stores the sample as rx_par, then enters STOP1.
- STOP1:
  - Samples the stop bit; a 0 sets the frame_err_int flag.
  - Goes to STOP2 if stop_bits=1, else completes.
- STOP2: samples again, ORs the result into frame_err_int, then completes.
- Completion cycle:
  - data_valid=1 for exactly one cycle.
  - data_out = shreg, with bit7 forced to 0 in 7-bit mode.
  - parity_err = parity_en & (rx_par != expected), where expected is computed over data_out.
  - frame_err = frame_err_int.
  - Next state is IDLE immediately, with no wait for the remainder of the stop bit. A start edge arriving half a bit after the stop sample is therefore caught.
- Output hold:
  - data_out, parity_err and frame_err hold until the next completion cycle.
  - data_valid is 0 at all other times.
- Break condition:
  - A line held low produces a frame of all-zero data with frame_err=1.
  - The block then waits in IDLE until rx_s returns to 1 before accepting a new start: an idle_armed flag is set by rx_s=1 and cleared on completion.
- Parity vs transmitter: the transmitter's parity covers all 8 data_in bits. In 7-bit mode its host must keep data_in[7]=0 for the two sides to agree.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit decision (start check, data, parity, stop) is the 2-of-3 majority of rx_s taken at cnt = target-1, target and target+1.
  - The decision is registered at target+1.
  - The next bit's counting is referenced to target, so bit spacing is unchanged.
  - Requires CLKS_PER_BIT >= 8.
- Undefined: single sample at target, as described above.

Test Plan:
- Basic 8N1 byte:
  - Stimulus: CLKS_PER_BIT=16, data_width=1, parity_en=0, stop_bits=0; drive 0x A5 LSB-first at 16 clk/bit.
  - Response: one data_valid pulse; data_out=0xA5, parity_err=0, frame_err=0; busy low the cycle after.
- 7-bit odd parity:
  - Stimulus: data_width=0, parity_en=1, parity_type=1; send 0x35 (four ones) with parity bit 1, then with parity bit 0.
  - Response: first frame data_out=0x35, parity_err=0; second frame parity_err=1.
- Framing error with two stop bits:
  - Stimulus: stop_bits=1; send 0x3C with the second stop bit driven 0.
  - Response: data_out=0x3C, frame_err=1; the next clean frame clears frame_err to 0.
- False start: a 3-clk low glitch on serial_in gives no data_valid, busy returns to 0, and data_out and the flags are unchanged.
- Back-to-back frames and reset:
  - Stimulus: send 0x00 then 0xFF with no idle gap; assert rst 5 bit times into a third frame.
  - Response: two data_valid pulses with 0x00 and 0xFF; after rst all outputs are 0 and no third data_valid.
- Break and noise:
  - Stimulus: hold serial_in low for 30 bit times.
  - Response: exactly one data_valid with data_out=0x00 and frame_err=1, then nothing until the line goes high and a new frame arrives.
  - With UART_RX_MAJORITY_VOTE_EN: a 1-clk inverted spike at each mid-bit of 0x5A still yields data_out=0x5A.
